packet_tx: RTL and testbench
============================

PACKET_TX -- requirements
Module: packet_tx

Interface
REQ-001 Parameter PKT_W, default 55, SHALL set the packet width in bits.
REQ-002 Parameter NBYTES, default 7, SHALL equal ceil(PKT_W/8) and set the number of link bytes per packet.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 pkt_in  input  PKT_W  SHALL carry the packet from the router buffer output.
REQ-006 pkt_valid  input  1  SHALL mark pkt_in as valid.
REQ-007 pkt_ready  output  1  SHALL be high when the holding register is empty and can accept pkt_in.
REQ-008 token_in  input  1  SHALL be a one-cycle pulse granting the ring token.
REQ-009 token_out  output  1  SHALL be a one-cycle pulse passing the token to the next node.
REQ-010 tx_data  output  8  SHALL carry the current link byte.
REQ-011 tx_valid  output  1  SHALL mark tx_data as valid.
REQ-012 tx_first  output  1  SHALL be high with byte 0 of each packet.
REQ-013 tx_ready  input  1  SHALL indicate that the link accepts tx_data this cycle.
REQ-014 pkt_sent  output  1  SHALL pulse for one cycle when the last byte is accepted.
REQ-015 token_err  output  1  SHALL be a sticky flag for a protocol violation.

Function
REQ-016 A packet SHALL load into the holding register on any edge where pkt_valid and pkt_ready are both high.
- pkt_ready = holding register empty, in any state.
REQ-017 The FSM SHALL have exactly three states: WAIT_TOKEN, SEND, PASS.
REQ-018 In WAIT_TOKEN with token_in high:
- holding register full -> SEND, byte index = 0.
- holding register empty -> PASS.
REQ-019 In WAIT_TOKEN with token_in high and a load on the same edge, the FSM SHALL go to PASS, because the register was empty when sampled.
REQ-020 In SEND, tx_valid SHALL be 1 and tx_data SHALL be byte[idx]; idx SHALL advance only on tx_valid and tx_ready.
REQ-021 Byte order SHALL be MSB first.
- byte0 = PKT_W bits [PKT_W-1 : 8*(NBYTES-1)], zero-extended to 8 bits; for PKT_W=55 this is {1'b0, pkt[54:48]}.
- byte k = pkt[8*(NBYTES-k)-1 : 8*(NBYTES-k-1)].
REQ-022 tx_first SHALL equal (state==SEND && idx==0).
REQ-023 tx_data and tx_valid SHALL hold stable while tx_ready is low.
REQ-024 Acceptance of byte NBYTES-1 SHALL:
- clear the holding register,
- pulse pkt_sent,
- move the FSM to PASS on the same edge.
REQ-025 In PASS, token_out SHALL be 1 for exactly one cycle and the FSM SHALL then return to WAIT_TOKEN.
REQ-026 Latency from token_in to byte 0 on tx_data SHALL be 1 cycle.
REQ-027 Latency from token_in to token_out with no packet held SHALL be 1 cycle.
REQ-028 token_in in SEND or PASS SHALL set token_err, with no other effect.
REQ-029 token_err SHALL clear only on reset.
REQ-030 idx SHALL be ceil(log2(NBYTES)) bits wide and SHALL never exceed NBYTES-1.
REQ-031 tx_data SHALL be 0 whenever tx_valid is 0.

Reset
REQ-032 rst_n low SHALL force, asynchronously:
- state = WAIT_TOKEN,
- holding register = 0 and empty,
- idx = 0,
- tx_data, tx_valid, tx_first, token_out, pkt_sent, token_err = 0,
- pkt_ready = 1 after deassertion.
REQ-033 Reset during SEND SHALL drop the packet and the token, with no token_out.

Structure
REQ-034 State encodings (WAIT_TOKEN=0, SEND=1, PASS=2) and PKT_W SHALL live in the shared router package, alongside the buffer select codes.
REQ-035 The byte-slicing multiplexer MAY be a sub-module, tx_byte_mux; all sequential logic SHALL remain in packet_tx.

Verification
REQ-036 Packet load and send:
- stimulus: load pkt_in=55'h12_3456_789A_BCDE, pulse token_in, tx_ready held 1.
- response: tx_data = 12,34,56,78,9A,BC,DE on consecutive cycles; tx_first on 12; pkt_sent with DE; token_out the next cycle.
REQ-037 Empty node:
- stimulus: token_in with the holding register empty.
- response: token_out exactly 1 cycle later; tx_valid never asserted.
REQ-038 Backpressure:
- stimulus: tx_ready low for 3 cycles at byte 2.
- response: tx_data stays 56 and tx_valid stays 1; the sequence completes intact.
REQ-039 Simultaneous load and token:
- stimulus: pkt_valid and token_in on the same edge with the register empty.
- response: token passed immediately; packet sent on the next token.
REQ-040 Token violation:
- stimulus: token_in during SEND.
- response: token_err=1 and the byte stream is unaffected.
REQ-041 Reset mid-send:
- stimulus: rst_n low at byte 3.
- response: all outputs 0 immediately; pkt_ready=1 after release; no token_out.

Source files
------------

// File: rtl/packet_tx_pkg.sv
// packet_tx_pkg: shared router constants, FSM state encodings and buffer select codes
package packet_tx_pkg;
  localparam int PKT_W = 55;
  typedef enum logic [1:0] {
    WAIT_TOKEN = 2'd0,
    SEND       = 2'd1,
    PASS       = 2'd2
  } state_t;
  typedef enum logic [2:0] {
    SEL_LOCAL = 3'd0,
    SEL_NORTH = 3'd1,
    SEL_EAST  = 3'd2,
    SEL_SOUTH = 3'd3,
    SEL_WEST  = 3'd4
  } buf_sel_t;
endpackage

// File: rtl/packet_tx_byte_mux.sv
// tx_byte_mux: selects link byte idx of a packet, MSB first, top byte zero-extended
// pkt: packet from the holding register; idx: byte index; sel_byte: selected byte
module tx_byte_mux #(
  parameter int PKT_W  = 55,
  parameter int NBYTES = 7,
  parameter int IW     = 3
) (
  input  logic [PKT_W-1:0] pkt,
  input  logic [IW-1:0]    idx,
  output logic [7:0]       sel_byte
);
  import packet_tx_pkg::*;
  logic [8*NBYTES-1:0] ext;
  assign ext      = (8*NBYTES)'(pkt);
  assign sel_byte = ext[8*(NBYTES-1-int'(idx)) +: 8];
endmodule

// File: rtl/packet_tx.sv
// packet_tx: token-ring node transmitter, holds one packet and sends it bytewise when granted the token
// pkt_in/pkt_valid/pkt_ready: packet load handshake into the holding register
// token_in/token_out: ring token grant in and pass-on pulse out
// tx_data/tx_valid/tx_first/tx_ready: byte link, pkt_sent pulses on the last accepted byte
// token_err: sticky flag for a token seen while not waiting for it
module packet_tx #(
  parameter int PKT_W  = packet_tx_pkg::PKT_W,
  parameter int NBYTES = (PKT_W + 7) / 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PKT_W-1:0] pkt_in,
  input  logic             pkt_valid,
  output logic             pkt_ready,
  input  logic             token_in,
  output logic             token_out,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  output logic             tx_first,
  input  logic             tx_ready,
  output logic             pkt_sent,
  output logic             token_err
);
  import packet_tx_pkg::*;
  localparam int IW = NBYTES > 1 ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);
  state_t            state;
  logic [PKT_W-1:0]  hold;
  logic              full;
  logic [IW-1:0]     idx;
  logic [7:0]        mux_byte;
  logic              send;
  tx_byte_mux #(.PKT_W(PKT_W), .NBYTES(NBYTES), .IW(IW)) u_mux (
    .pkt      (hold),
    .idx      (idx),
    .sel_byte (mux_byte)
  );
  // All link outputs decode straight from registered state, so they drop with reset asynchronously
  assign send      = state == SEND;
  assign pkt_ready = !full;
  assign tx_valid  = send;
  assign tx_first  = send && idx == '0;
  assign tx_data   = send ? mux_byte : 8'h00;
  assign pkt_sent  = send && tx_ready && idx == LAST;
  assign token_out = state == PASS;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_TOKEN;
      hold      <= '0;
      full      <= 1'b0;
      idx       <= '0;
      token_err <= 1'b0;
    end else begin
      if (pkt_valid && !full) begin
        hold <= pkt_in;
        full <= 1'b1;
      end
      if (token_in && state != WAIT_TOKEN) token_err <= 1'b1;
      case (state)
        // full is the pre-edge value, so a same-edge load still passes the token
        WAIT_TOKEN: if (token_in) begin
          state <= full ? SEND : PASS;
          idx   <= '0;
        end
        SEND: if (tx_ready) begin
          if (idx == LAST) begin
            state <= PASS;
            full  <= 1'b0;
            hold  <= '0;
            idx   <= '0;
          end else idx <= idx + 1'b1;
        end
        PASS:    state <= WAIT_TOKEN;
        default: state <= WAIT_TOKEN;
      endcase
    end
  end
endmodule

// File: tb/tb_packet_tx.sv
// tb_packet_tx: table-driven cycle vectors plus a hand-written reset-mid-send sequence
module tb_packet_tx;
  localparam int PKT_W = 55;
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [PKT_W-1:0] pkt_in = '0;
  logic             pkt_valid = 1'b0, token_in = 1'b0, tx_ready = 1'b1;
  logic             pkt_ready, token_out, tx_valid, tx_first, pkt_sent, token_err;
  logic [7:0]       tx_data;
  int checks = 0, errors = 0;
  packet_tx dut (
    .clk(clk), .rst_n(rst_n), .pkt_in(pkt_in), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .token_in(token_in), .token_out(token_out), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_first(tx_first), .tx_ready(tx_ready), .pkt_sent(pkt_sent), .token_err(token_err)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic pv, tok, rdy;
    logic v;
    logic [7:0] d;
    logic f, s, to, pr, er;
  } vec_t;
  vec_t tbl[$];
  task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic add(input logic pv, tok, rdy, v, input logic [7:0] d, input logic f, s, to, pr, er);
    vec_t r;
    r = '{pv, tok, rdy, v, d, f, s, to, pr, er};
    tbl.push_back(r);
  endtask
  task automatic chk_all(input string p, input logic v, input logic [7:0] d, input logic f, s, to, pr, er);
    chk({p, " tx_valid"}, tx_valid, v);
    chk({p, " tx_data"}, tx_data, d);
    chk({p, " tx_first"}, tx_first, f);
    chk({p, " pkt_sent"}, pkt_sent, s);
    chk({p, " token_out"}, token_out, to);
    chk({p, " pkt_ready"}, pkt_ready, pr);
    chk({p, " token_err"}, token_err, er);
  endtask
  task automatic send_rows(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, input logic er);
    add(0,0,1, 1,b0,1,0,0,0,er);
    add(0,0,1, 1,b1,0,0,0,0,er);
    add(0,0,1, 1,b2,0,0,0,0,er);
    add(0,0,1, 1,b3,0,0,0,0,er);
    add(0,0,1, 1,b4,0,0,0,0,er);
    add(0,0,1, 1,b5,0,0,0,0,er);
    add(0,0,1, 1,b6,0,1,0,0,er);
  endtask
  initial begin
    // load, token, send with 3-cycle stall at byte 2 and a token violation during the stall
    add(0,0,1, 0,8'h00,0,0,0,1,0);
    add(1,0,1, 0,8'h00,0,0,0,1,0);
    add(0,1,1, 0,8'h00,0,0,0,0,0);
    add(0,0,1, 1,8'h12,1,0,0,0,0);
    add(0,0,1, 1,8'h34,0,0,0,0,0);
    add(0,0,0, 1,8'h56,0,0,0,0,0);
    add(0,1,0, 1,8'h56,0,0,0,0,0);
    add(0,0,0, 1,8'h56,0,0,0,0,1);
    add(0,0,1, 1,8'h56,0,0,0,0,1);
    add(0,0,1, 1,8'h78,0,0,0,0,1);
    add(0,0,1, 1,8'h9A,0,0,0,0,1);
    add(0,0,1, 1,8'hBC,0,0,0,0,1);
    add(0,0,1, 1,8'hDE,0,1,0,0,1);
    add(0,0,1, 0,8'h00,0,0,1,1,1);
    add(0,0,1, 0,8'h00,0,0,0,1,1);
    // empty node: token passes after one cycle, no bytes
    add(0,1,1, 0,8'h00,0,0,0,1,1);
    add(0,0,1, 0,8'h00,0,0,1,1,1);
    add(0,0,1, 0,8'h00,0,0,0,1,1);
    // load and token on the same edge: token passes, packet goes on next token
    add(1,1,1, 0,8'h00,0,0,0,1,1);
    add(0,0,1, 0,8'h00,0,0,1,0,1);
    add(0,0,1, 0,8'h00,0,0,0,0,1);
    add(0,1,1, 0,8'h00,0,0,0,0,1);
    send_rows(8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 1);
    add(0,0,1, 0,8'h00,0,0,1,1,1);
    add(0,0,1, 0,8'h00,0,0,0,1,1);
    pkt_in = 55'h12_3456_789A_BCDE;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    foreach (tbl[i]) begin
      @(negedge clk);
      pkt_valid = tbl[i].pv;
      token_in  = tbl[i].tok;
      tx_ready  = tbl[i].rdy;
      #1;
      chk_all($sformatf("row%0d", i), tbl[i].v, tbl[i].d, tbl[i].f, tbl[i].s, tbl[i].to, tbl[i].pr, tbl[i].er);
    end
    // reset at byte 3 of an all-ones packet (byte 0 is the zero-extended top 7 bits)
    @(negedge clk);
    pkt_in = '1; pkt_valid = 1'b1; token_in = 1'b0; tx_ready = 1'b1;
    @(negedge clk);
    pkt_valid = 1'b0; token_in = 1'b1;
    @(negedge clk);
    token_in = 1'b0;
    #1 chk("ones byte0", tx_data, 8'h7F);
    chk("ones first", tx_first, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      #1 chk($sformatf("ones byte%0d", k), tx_data, 8'hFF);
    end
    rst_n = 1'b0;
    #1 chk_all("in reset", 0, 8'h00, 0, 0, 0, 1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post-reset pkt_ready", pkt_ready, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1 chk($sformatf("post-reset c%0d token_out", k), token_out, 1'b0);
      chk($sformatf("post-reset c%0d tx_valid", k), tx_valid, 1'b0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
